// File: rtl/tpu_job_sched_if.sv
// Bundle of the host command, tpu control/config, completion and status signals of tpu_job_sched.
// Latency: none; this is plain wiring between the scheduler and its neighbours.
// Backpressure: carries cmd valid/ready and done valid/ready handshakes unchanged.
interface tpu_job_sched_if #(
    parameter int ADDR_WIDTH = 12,
    parameter int DEPTH      = 4
);
    logic                  cmd_valid_i;
    logic                  cmd_ready_o;
    logic [ADDR_WIDTH-1:0] cmd_m_i;
    logic [ADDR_WIDTH-1:0] cmd_k_i;
    logic [ADDR_WIDTH-1:0] cmd_n_i;
    logic [ADDR_WIDTH-1:0] cmd_base_a_i;
    logic [ADDR_WIDTH-1:0] cmd_base_b_i;
    logic [ADDR_WIDTH-1:0] cmd_base_p_i;
    logic [3:0]            cmd_tag_i;

    logic                  tpu_start_o;
    logic                  tpu_valid_i;
    logic [ADDR_WIDTH-1:0] tpu_m_o;
    logic [ADDR_WIDTH-1:0] tpu_k_o;
    logic [ADDR_WIDTH-1:0] tpu_n_o;
    logic [ADDR_WIDTH-1:0] tpu_base_a_o;
    logic [ADDR_WIDTH-1:0] tpu_base_b_o;
    logic [ADDR_WIDTH-1:0] tpu_base_p_o;

    logic                  done_valid_o;
    logic                  done_ready_i;
    logic [3:0]            done_tag_o;
    logic [1:0]            done_status_o;

    logic                  busy_o;
    logic [$clog2(DEPTH):0] pending_o;
    logic                  hang_o;

    // Scheduler side.
    modport slave (
        input  cmd_valid_i, cmd_m_i, cmd_k_i, cmd_n_i,
               cmd_base_a_i, cmd_base_b_i, cmd_base_p_i, cmd_tag_i,
               tpu_valid_i, done_ready_i,
        output cmd_ready_o, tpu_start_o,
               tpu_m_o, tpu_k_o, tpu_n_o, tpu_base_a_o, tpu_base_b_o, tpu_base_p_o,
               done_valid_o, done_tag_o, done_status_o,
               busy_o, pending_o, hang_o
    );

    // Host / tpu side.
    modport master (
        output cmd_valid_i, cmd_m_i, cmd_k_i, cmd_n_i,
               cmd_base_a_i, cmd_base_b_i, cmd_base_p_i, cmd_tag_i,
               tpu_valid_i, done_ready_i,
        input  cmd_ready_o, tpu_start_o,
               tpu_m_o, tpu_k_o, tpu_n_o, tpu_base_a_o, tpu_base_b_o, tpu_base_p_o,
               done_valid_o, done_tag_o, done_status_o,
               busy_o, pending_o, hang_o
    );
endinterface

// File: rtl/tpu_job_sched.sv
// Purpose: queues tpu matmul jobs, launches one at a time, returns tagged completion records; TPU_SCHED_TIMEOUT_EN adds a WAIT watchdog.
// Latency: job accepted at edge N pops at N+1, start pulse in the cycle after N+1; completion visible from the edge that sees tpu valid.
// Backpressure: cmd_ready_o low when FIFO full or hung; completion record held stable until done_ready_i.
module tpu_job_sched #(
    parameter int ADDR_WIDTH     = 12,
    parameter int DEPTH          = 4,
    parameter int TIMEOUT_CYCLES = 4096
) (
    input  logic           clk_i,
    input  logic           rst_ni,
    tpu_job_sched_if.slave bus
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    typedef enum logic [2:0] {S_IDLE, S_LAUNCH, S_WAIT, S_REPORT, S_HALT} state_t;

    typedef struct packed {
        logic [ADDR_WIDTH-1:0] m;
        logic [ADDR_WIDTH-1:0] k;
        logic [ADDR_WIDTH-1:0] n;
        logic [ADDR_WIDTH-1:0] base_a;
        logic [ADDR_WIDTH-1:0] base_b;
        logic [ADDR_WIDTH-1:0] base_p;
        logic [3:0]            tag;
    } job_t;

    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 || TIMEOUT_CYCLES < 2) begin : g_bad_param
        $error("tpu_job_sched: DEPTH must be a power of two >= 2 and TIMEOUT_CYCLES >= 2");
    end

    state_t         state_q, state_d;
    job_t           fifo_q [DEPTH];
    job_t           fifo_d [DEPTH];
    logic [PW-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]  count_q, count_d;
    logic           init_q, init_d;
    job_t           cfg_q, cfg_d;
    logic           armed_q, armed_d;
    logic           start_q, start_d;
    logic           done_vld_q, done_vld_d;
    logic [1:0]     status_q, status_d;
    logic           hang;
    logic           push;
    logic           pop;
    job_t           head;

`ifdef TPU_SCHED_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES);
    logic [TW-1:0]  tmo_q, tmo_d;
    logic           hang_q, hang_d;
    assign hang = hang_q;
`else
    assign hang = 1'b0;
`endif

    // init_q keeps cmd_ready_o low while reset is asserted and until the first clock after release.
    assign bus.cmd_ready_o = init_q && (count_q < CW'(DEPTH)) && !hang;
    assign push            = bus.cmd_valid_i && bus.cmd_ready_o;
    assign pop             = (state_q == S_IDLE) && (count_q != '0);
    assign head            = fifo_q[rd_ptr_q];

    // FIFO bookkeeping plus scheduler FSM next-state and registered-output logic.
    always_comb begin
        state_d    = state_q;
        fifo_d     = fifo_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        init_d     = 1'b1;
        cfg_d      = cfg_q;
        armed_d    = armed_q;
        start_d    = 1'b0;
        done_vld_d = done_vld_q;
        status_d   = status_q;
`ifdef TPU_SCHED_TIMEOUT_EN
        tmo_d      = tmo_q;
        hang_d     = hang_q;
`endif

        if (push) begin
            fifo_d[wr_ptr_q] = '{m: bus.cmd_m_i, k: bus.cmd_k_i, n: bus.cmd_n_i,
                                 base_a: bus.cmd_base_a_i, base_b: bus.cmd_base_b_i,
                                 base_p: bus.cmd_base_p_i, tag: bus.cmd_tag_i};
            wr_ptr_d = wr_ptr_q + PW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
        end
        case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase

        case (state_q)
            S_IDLE: begin
                if (pop) begin
                    cfg_d   = head;
                    armed_d = 1'b0;
                    if (head.m == '0 || head.k == '0 || head.n == '0) begin
                        // Malformed job: report straight away, the core never sees it.
                        state_d    = S_REPORT;
                        done_vld_d = 1'b1;
                        status_d   = 2'b01;
                    end else begin
                        state_d = S_LAUNCH;
                        start_d = 1'b1;
                    end
                end
            end
            S_LAUNCH: begin
                state_d = S_WAIT;
`ifdef TPU_SCHED_TIMEOUT_EN
                tmo_d   = '0;
`endif
            end
            S_WAIT: begin
                if (armed_q && bus.tpu_valid_i) begin
                    state_d    = S_REPORT;
                    done_vld_d = 1'b1;
                    status_d   = 2'b00;
                end else begin
                    // A valid level still high from the previous job is ignored until it has dropped once.
                    if (!bus.tpu_valid_i) begin
                        armed_d = 1'b1;
                    end
`ifdef TPU_SCHED_TIMEOUT_EN
                    if (tmo_q == TW'(TIMEOUT_CYCLES - 1)) begin
                        state_d    = S_REPORT;
                        done_vld_d = 1'b1;
                        status_d   = 2'b10;
                        hang_d     = 1'b1;
                    end else begin
                        tmo_d = tmo_q + TW'(1);
                    end
`endif
                end
            end
            S_REPORT: begin
                if (bus.done_ready_i) begin
                    done_vld_d = 1'b0;
                    state_d    = (status_q == 2'b10) ? S_HALT : S_IDLE;
                end
            end
            S_HALT: begin
                state_d = S_HALT;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State, FIFO and registered outputs; reset drops queued jobs and any pending completion.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= S_IDLE;
            for (int i = 0; i < DEPTH; i++) begin
                fifo_q[i] <= '0;
            end
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            init_q     <= 1'b0;
            cfg_q      <= '0;
            armed_q    <= 1'b0;
            start_q    <= 1'b0;
            done_vld_q <= 1'b0;
            status_q   <= 2'b00;
        end else begin
            state_q    <= state_d;
            fifo_q     <= fifo_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            init_q     <= init_d;
            cfg_q      <= cfg_d;
            armed_q    <= armed_d;
            start_q    <= start_d;
            done_vld_q <= done_vld_d;
            status_q   <= status_d;
        end
    end

`ifdef TPU_SCHED_TIMEOUT_EN
    // Watchdog counter and sticky hang flag.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            tmo_q  <= '0;
            hang_q <= 1'b0;
        end else begin
            tmo_q  <= tmo_d;
            hang_q <= hang_d;
        end
    end
`endif

    assign bus.tpu_start_o   = start_q;
    assign bus.tpu_m_o       = cfg_q.m;
    assign bus.tpu_k_o       = cfg_q.k;
    assign bus.tpu_n_o       = cfg_q.n;
    assign bus.tpu_base_a_o  = cfg_q.base_a;
    assign bus.tpu_base_b_o  = cfg_q.base_b;
    assign bus.tpu_base_p_o  = cfg_q.base_p;
    assign bus.done_valid_o  = done_vld_q;
    assign bus.done_tag_o    = cfg_q.tag;
    assign bus.done_status_o = status_q;
    assign bus.busy_o        = (state_q != S_IDLE);
    assign bus.pending_o     = count_q;
    assign bus.hang_o        = hang;
endmodule
